// File: rtl/neighbor_builder.sv
// Builds the per-vertex neighbor table: clears one row per vertex, then walks every
// face edge and inserts each endpoint into the other's row, skipping duplicates.
module neighbor_builder #(
  parameter int ADDR_WIDTH         = 9,
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           vertex_count,
  input  logic [31:0]           face_count,
  input  logic [31:0]           RAM_OBJ_Do,
  input  logic [31:0]           RAM_NBR_Do,
  output logic                  RAM_OBJ_EN,
  output logic                  RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [3:0]            RAM_OBJ_WE,
  output logic [3:0]            RAM_NBR_WE,
  output logic [31:0]           RAM_OBJ_Di,
  output logic [31:0]           RAM_NBR_Di,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  bad_index
);

  localparam int DATA_W = 32;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam addr_t             STRIDE   = addr_t'(MAX_NEIGHBOR_COUNT);
  localparam logic [DATA_W-1:0] ROW_FULL = DATA_W'(MAX_NEIGHBOR_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FACE_RD, S_CNT_RD, S_SCAN, S_APPEND, S_DONE
  } state_t;

  state_t            state, state_d, edge_next, ins_next;
  logic [DATA_W-1:0] cnt, v_num, f_num, face_cnt, va, vb, vc, n;
  logic [DATA_W-1:0] p, q, u, w;
  logic [1:0]        edge_sel;
  logic              dir;
  addr_t             face_base, row_base, nbr_a, obj_a;
  logic [DATA_W-1:0] nbr_di;
  logic [3:0]        nbr_we;
  logic              edge_bad, last_face, cnt_clr, adv_ins, adv_edge, skip;
  logic              set_ovf, set_bad;

  always_comb begin
    p = va;
    q = vb;
    case (edge_sel)
      2'd0:    begin p = va; q = vb; end
      2'd1:    begin p = vb; q = vc; end
      default: begin p = vc; q = va; end
    endcase
    u         = dir ? q : p;
    w         = dir ? p : q;
    edge_bad  = (p == '0) || (p > v_num) || (q == '0) || (q > v_num);
    row_base  = (addr_t'(u) - addr_t'(1)) * STRIDE;
    last_face = (face_cnt == f_num - 1);
    edge_next = (edge_sel != 2'd2) ? S_CNT_RD : (last_face ? S_DONE : S_FACE_RD);
    ins_next  = dir ? edge_next : S_CNT_RD;
  end

  always_comb begin
    state_d = state;
    adv_ins = 1'b0;
    skip    = 1'b0;
    set_ovf = 1'b0;
    set_bad = 1'b0;
    nbr_a   = '0;
    nbr_di  = '0;
    nbr_we  = 4'h0;
    obj_a   = '0;
    case (state)
      S_IDLE: if (start) state_d = (vertex_count == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: begin
        nbr_a  = addr_t'(cnt) * STRIDE;
        nbr_we = 4'hF;
        if (cnt == v_num - 1) state_d = (f_num != '0) ? S_FACE_RD : S_DONE;
      end
      S_FACE_RD: begin
        obj_a = face_base + addr_t'(cnt);
        if (cnt == 32'd3) state_d = S_CNT_RD;
      end
      S_CNT_RD: begin
        nbr_a = row_base;
        if (cnt == '0) begin
          if (edge_bad) begin
            set_bad = 1'b1;
            skip    = 1'b1;
            state_d = edge_next;
          end
        end else begin
          state_d = (RAM_NBR_Do == '0) ? S_APPEND : S_SCAN;
        end
      end
      S_SCAN: begin
        // Reads run one word ahead of the compare; cnt==n only compares.
        if (cnt < n) nbr_a = row_base + addr_t'(cnt) + addr_t'(1);
        if (cnt != '0 && RAM_NBR_Do == w) begin
          adv_ins = 1'b1;
          state_d = ins_next;
        end else if (cnt == n) begin
          state_d = S_APPEND;
        end
      end
      S_APPEND: begin
        if (n >= ROW_FULL) begin
          set_ovf = 1'b1;
          adv_ins = 1'b1;
          state_d = ins_next;
        end else if (cnt == '0) begin
          nbr_a  = row_base + addr_t'(n) + addr_t'(1);
          nbr_di = w;
          nbr_we = 4'hF;
        end else begin
          nbr_a   = row_base;
          nbr_di  = n + 1;
          nbr_we  = 4'hF;
          adv_ins = 1'b1;
          state_d = ins_next;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    adv_edge = skip | (adv_ins & dir);
    cnt_clr  = (state_d != state) | adv_ins | skip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      face_cnt  <= '0;
      edge_sel  <= 2'd0;
      dir       <= 1'b0;
      overflow  <= 1'b0;
      bad_index <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_clr ? '0 : cnt + 1;
      if (state == S_IDLE && start) begin
        face_cnt  <= '0;
        edge_sel  <= 2'd0;
        dir       <= 1'b0;
        overflow  <= 1'b0;
        bad_index <= 1'b0;
      end
      if (set_ovf) overflow <= 1'b1;
      if (set_bad) bad_index <= 1'b1;
      if (adv_ins && !dir) dir <= 1'b1;
      if (adv_edge) begin
        dir <= 1'b0;
        if (edge_sel != 2'd2) begin
          edge_sel <= edge_sel + 2'd1;
        end else begin
          edge_sel <= 2'd0;
          face_cnt <= face_cnt + 1;
        end
      end
    end
  end

  // Run parameters, face vertices and row count are re-loaded before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      v_num     <= vertex_count;
      f_num     <= face_count;
      face_base <= addr_t'(32'd3 * vertex_count + 32'd1);
    end
    if (adv_edge && edge_sel == 2'd2) face_base <= face_base + addr_t'(3);
    if (state == S_FACE_RD) begin
      case (cnt[1:0])
        2'd1:    va <= RAM_OBJ_Do;
        2'd2:    vb <= RAM_OBJ_Do;
        2'd3:    vc <= RAM_OBJ_Do;
        default: ;
      endcase
    end
    if (state == S_CNT_RD && cnt == 32'd1) n <= RAM_NBR_Do;
  end

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign RAM_OBJ_EN = busy;
  assign RAM_NBR_EN = busy;
  assign RAM_OBJ_A  = obj_a;
  assign RAM_OBJ_WE = 4'h0;
  assign RAM_OBJ_Di = '0;
  assign RAM_NBR_A  = nbr_a;
  assign RAM_NBR_WE = nbr_we;
  assign RAM_NBR_Di = nbr_di;

endmodule

// File: tb/tb_neighbor_builder.sv
// Bench for neighbor_builder: behavioural RAMs plus a set/queue model of the neighbor table.
module tb_neighbor_builder;
  localparam int AW   = 9;
  localparam int MAXN = 10;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [31:0]   vertex_count, face_count, RAM_OBJ_Do, RAM_NBR_Do;
  logic          RAM_OBJ_EN, RAM_NBR_EN;
  logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
  logic [3:0]    RAM_OBJ_WE, RAM_NBR_WE;
  logic [31:0]   RAM_OBJ_Di, RAM_NBR_Di;
  logic          busy, done, overflow, bad_index;

  always #5 clk = ~clk;

  neighbor_builder #(.ADDR_WIDTH(AW), .MAX_NEIGHBOR_COUNT(MAXN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vertex_count(vertex_count), .face_count(face_count),
    .RAM_OBJ_Do(RAM_OBJ_Do), .RAM_NBR_Do(RAM_NBR_Do),
    .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_NBR_EN(RAM_NBR_EN),
    .RAM_OBJ_A(RAM_OBJ_A), .RAM_NBR_A(RAM_NBR_A),
    .RAM_OBJ_WE(RAM_OBJ_WE), .RAM_NBR_WE(RAM_NBR_WE),
    .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_NBR_Di(RAM_NBR_Di),
    .busy(busy), .done(done), .overflow(overflow), .bad_index(bad_index)
  );

  logic [31:0]   obj_mem [512];
  logic [31:0]   nbr_mem [512];
  logic          ld_obj = 1'b0, ld_nbr = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [31:0]   ld_d = '0;
  int nbr_writes = 0, stray_writes = 0, obj_writes = 0, done_pulses = 0;

  always @(posedge clk) begin
    if (ld_obj) obj_mem[ld_a] <= ld_d;
    else if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
  end

  always @(posedge clk) begin
    if (ld_nbr) nbr_mem[ld_a] <= ld_d;
    else if (RAM_NBR_EN) begin
      for (int i = 0; i < 4; i++)
        if (RAM_NBR_WE[i]) nbr_mem[RAM_NBR_A][8*i +: 8] <= RAM_NBR_Di[8*i +: 8];
      RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
    end
  end

  always @(posedge clk) begin
    if (RAM_OBJ_WE != 4'h0 || RAM_OBJ_Di != 32'h0) obj_writes <= obj_writes + 1;
    if (RAM_NBR_WE != 4'h0) begin
      nbr_writes <= nbr_writes + 1;
      if (!(busy && RAM_NBR_EN)) stray_writes <= stray_writes + 1;
    end
    if (done) done_pulses <= done_pulses + 1;
  end

  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Face list and reference neighbor sets
  int unsigned fa[$], fb[$], fc[$];
  int unsigned rows[64][$];
  bit exp_ovf, exp_bad;
  int exp_entries;

  task automatic add_face(input int unsigned a, input int unsigned b, input int unsigned c);
    fa.push_back(a); fb.push_back(b); fc.push_back(c);
  endtask

  task automatic clear_faces();
    fa.delete(); fb.delete(); fc.delete();
  endtask

  task automatic model_insert(input int unsigned owner, input int unsigned nb);
    foreach (rows[owner][j]) if (rows[owner][j] == nb) return;
    if (rows[owner].size() == MAXN - 1) exp_ovf = 1;
    else begin
      rows[owner].push_back(nb);
      exp_entries++;
    end
  endtask

  task automatic build_model(input int v);
    int unsigned t[3];
    for (int k = 0; k < 64; k++) rows[k].delete();
    exp_ovf = 0; exp_bad = 0; exp_entries = 0;
    foreach (fa[f]) begin
      t[0] = fa[f]; t[1] = fb[f]; t[2] = fc[f];
      for (int e = 0; e < 3; e++) begin
        int unsigned x, y;
        x = t[e]; y = t[(e + 1) % 3];
        if (x == 0 || x > v || y == 0 || y > v) exp_bad = 1;
        else begin
          model_insert(x, y);
          model_insert(y, x);
        end
      end
    end
  endtask

  task automatic poke(input bit to_obj, input int a, input logic [31:0] d);
    @(negedge clk);
    ld_obj = to_obj; ld_nbr = !to_obj; ld_a = AW'(a); ld_d = d;
  endtask

  task automatic load(input int v);
    for (int k = 1; k <= 3 * v; k++) poke(1'b1, k, $urandom);
    foreach (fa[f]) begin
      poke(1'b1, 3 * v + 1 + 3 * f, fa[f]);
      poke(1'b1, 3 * v + 2 + 3 * f, fb[f]);
      poke(1'b1, 3 * v + 3 + 3 * f, fc[f]);
    end
    for (int k = 0; k < v * MAXN; k++) poke(1'b0, k, 32'hBAD0_0000 | k);
    @(negedge clk);
    ld_obj = 1'b0; ld_nbr = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int v, input bit inject);
    int wb, db;
    bit got;
    build_model(v);
    load(v);
    vertex_count = v;
    face_count   = fa.size();
    wb = nbr_writes; db = done_pulses;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, ".busy_rise"}, busy, 1);
    got = 0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      start = inject && (t == 5);
      if (inject && t == 5) vertex_count = v + 3;
      if (done) begin got = 1; break; end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, got, 1);
    check({tag, ".overflow"}, overflow, exp_ovf);
    check({tag, ".bad_index"}, bad_index, exp_bad);
    @(negedge clk);
    check({tag, ".done_width"}, done, 0);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".done_count"}, done_pulses - db, 1);
    check({tag, ".write_count"}, nbr_writes - wb, v + 2 * exp_entries);
    for (int k = 1; k <= v; k++) begin
      int base;
      base = (k - 1) * MAXN;
      check($sformatf("%s.row%0d.n", tag, k), nbr_mem[base], rows[k].size());
      foreach (rows[k][j])
        check($sformatf("%s.row%0d.e%0d", tag, k, j), nbr_mem[base + 1 + j], rows[k][j]);
    end
  endtask

  initial begin
    int db, wb, v, nf, r;
    bit found;
    rst = 1'b1; start = 1'b0; vertex_count = '0; face_count = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.flags", {overflow, bad_index}, 0);
    check("rst.en", {RAM_OBJ_EN, RAM_NBR_EN}, 0);
    check("rst.we", {RAM_OBJ_WE, RAM_NBR_WE}, 0);
    check("rst.addr", {RAM_OBJ_A, RAM_NBR_A}, 0);
    check("rst.di_obj", RAM_OBJ_Di, 0);
    check("rst.di_nbr", RAM_NBR_Di, 0);
    rst = 1'b0;

    clear_faces(); add_face(1, 2, 3);
    run_and_check("tri", 3, 0);
    check("tri.row0_cnt", nbr_mem[0], 2);
    check("tri.row0_e0", nbr_mem[1], 2);
    check("tri.row0_e1", nbr_mem[2], 3);
    check("tri.row2_e1", nbr_mem[22], 1);

    clear_faces(); add_face(1, 2, 3); add_face(1, 3, 4);
    run_and_check("quad", 4, 0);
    check("quad.row0_cnt", nbr_mem[0], 3);
    check("quad.row0_e2", nbr_mem[3], 4);
    check("quad.row3_e1", nbr_mem[32], 1);

    clear_faces(); add_face(1, 2, 5);
    run_and_check("bad", 3, 0);
    check("bad.flag", bad_index, 1);
    check("bad.row2_cnt", nbr_mem[20], 0);

    clear_faces();
    for (int k = 2; k <= 11; k++) add_face(1, k, k + 1);
    run_and_check("fan", 12, 0);
    check("fan.ovf", overflow, 1);
    check("fan.row0_full", nbr_mem[0], MAXN - 1);

    // Reset while scanning a row, then a clean rerun
    clear_faces(); add_face(1, 2, 3); add_face(1, 3, 4);
    load(4);
    vertex_count = 4; face_count = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int t = 0; t < 2000; t++) begin
      if (busy && RAM_NBR_EN && RAM_NBR_WE == 4'h0 && (RAM_NBR_A % MAXN) != 0) begin
        found = 1; break;
      end
      @(negedge clk);
    end
    check("rstscan.found", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstscan.busy", busy, 0);
    check("rstscan.we", RAM_NBR_WE, 0);
    check("rstscan.en", RAM_NBR_EN, 0);
    rst = 1'b0;
    run_and_check("rerun", 4, 0);

    // Reset and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start.busy", busy, 0);

    // V=0: done the cycle after start, no writes
    wb = nbr_writes; db = done_pulses;
    vertex_count = 0; face_count = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("v0.done", done, 1);
    check("v0.busy", busy, 0);
    @(negedge clk);
    check("v0.done_width", done, 0);
    check("v0.writes", nbr_writes - wb, 0);
    check("v0.done_count", done_pulses - db, 1);

    clear_faces();
    run_and_check("f0", 5, 0);

    for (int run = 0; run < 12; run++) begin
      v  = $urandom_range(3, 20);
      nf = $urandom_range(1, 8);
      clear_faces();
      for (int f = 0; f < nf; f++) begin
        int unsigned idx[3];
        for (int j = 0; j < 3; j++) begin
          r = $urandom_range(0, 19);
          idx[j] = (r == 0) ? 0 : (r == 1) ? v + 1 : $urandom_range(1, v);
        end
        add_face(idx[0], idx[1], idx[2]);
      end
      run_and_check($sformatf("rnd%0d", run), v, run[0]);
    end

    check("obj_never_written", obj_writes, 0);
    check("no_stray_nbr_writes", stray_writes, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
